// File: rtl/sum_stage_if.sv
// Purpose: sync/notify handshake bundle between sum_stage and its neighbours.
// Latency: none (wires only).
// Backpressure: notify/sync pairs; a transfer happens only when both are high.
// Signals:
//   sum_in / sum_in_sync / sum_in_notify     upstream sample stream
//   flush                                    early emit of a partial sum
//   sum_out / ovf_out / sum_out_sync / sum_out_notify   downstream result
// Modports: master = the environment around the block, slave = sum_stage.
interface sum_stage_if;
    logic signed [31:0] sum_in;
    logic               sum_in_sync;
    logic               sum_in_notify;
    logic               flush;
    logic signed [31:0] sum_out;
    logic               ovf_out;
    logic               sum_out_sync;
    logic               sum_out_notify;

    modport master (
        output sum_in, sum_in_sync, flush, sum_out_sync,
        input  sum_in_notify, sum_out, ovf_out, sum_out_notify
    );

    modport slave (
        input  sum_in, sum_in_sync, flush, sum_out_sync,
        output sum_in_notify, sum_out, ovf_out, sum_out_notify
    );
endinterface

// File: rtl/sum_stage.sv
// Purpose: accumulates COUNT signed samples (fewer on flush) and emits their sum.
// Latency: sum_out_notify is visible the cycle after the final input transfer.
// Backpressure: holds the result in WRITE while sum_out_sync is low; input stalls.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       sum_stage_if.slave (sum_in/sync/notify, flush, sum_out/ovf_out/sync/notify)
// Option: define SUM_STAGE_SAT_EN for saturating adds with a sticky overflow flag;
//         without it additions wrap and ovf_out is tied low.
module sum_stage #(
    parameter int unsigned COUNT = 4   // samples per sum, 1..255
) (
    input logic         clk,
    input logic         rst,
    sum_stage_if.slave  bus
);
    typedef enum logic {READ, WRITE} state_t;

    localparam logic [7:0] COUNT_W = 8'(COUNT);

    state_t             state;
    logic               in_notify_q;
    logic               out_notify_q;
    logic signed [31:0] sum_out_q;
    logic signed [31:0] acc;
    logic [7:0]         cnt;
    logic [7:0]         cnt_inc;
    logic signed [31:0] add_res;

    assign cnt_inc = cnt + 8'd1;

`ifdef SUM_STAGE_SAT_EN
    logic               ovf;
    logic               ovf_out_q;
    logic               ovf_nxt;
    logic signed [32:0] sum_ext;
    logic               add_ovf;

    // Sign-extended add: bit 32 != bit 31 exactly when the carry into bit 31
    // differs from the carry out of it, and bit 32 then gives the true sign.
    always_comb begin
        sum_ext = {acc[31], acc} + {bus.sum_in[31], bus.sum_in};
        add_ovf = sum_ext[32] ^ sum_ext[31];
        if (add_ovf)
            add_res = sum_ext[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        else
            add_res = sum_ext[31:0];
        ovf_nxt = ovf | add_ovf;
    end

    assign bus.ovf_out = ovf_out_q;
`else
    assign add_res     = acc + bus.sum_in;
    assign bus.ovf_out = 1'b0;
`endif

    assign bus.sum_in_notify  = in_notify_q;
    assign bus.sum_out_notify = out_notify_q;
    assign bus.sum_out        = sum_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= READ;
            in_notify_q  <= 1'b1;
            out_notify_q <= 1'b0;
            sum_out_q    <= '0;
            acc          <= '0;
            cnt          <= '0;
`ifdef SUM_STAGE_SAT_EN
            ovf          <= 1'b0;
            ovf_out_q    <= 1'b0;
`endif
        end else begin
            case (state)
                READ: begin
                    if (bus.sum_in_sync) begin
                        if (cnt_inc == COUNT_W || bus.flush) begin
                            // Final sample (or flushed one): publish and clear.
                            sum_out_q    <= add_res;
                            acc          <= '0;
                            cnt          <= '0;
                            state        <= WRITE;
                            in_notify_q  <= 1'b0;
                            out_notify_q <= 1'b1;
`ifdef SUM_STAGE_SAT_EN
                            ovf_out_q    <= ovf_nxt;
                            ovf          <= 1'b0;
`endif
                        end else begin
                            acc <= add_res;
                            cnt <= cnt_inc;
`ifdef SUM_STAGE_SAT_EN
                            ovf <= ovf_nxt;
`endif
                        end
                    end else if (bus.flush && cnt != 8'd0) begin
                        // Flush without a sample emits what has been gathered;
                        // an empty accumulator never produces a packet.
                        sum_out_q    <= acc;
                        acc          <= '0;
                        cnt          <= '0;
                        state        <= WRITE;
                        in_notify_q  <= 1'b0;
                        out_notify_q <= 1'b1;
`ifdef SUM_STAGE_SAT_EN
                        ovf_out_q    <= ovf;
                        ovf          <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    if (bus.sum_out_sync) begin
                        state        <= READ;
                        in_notify_q  <= 1'b1;
                        out_notify_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= READ;
                    in_notify_q  <= 1'b1;
                    out_notify_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sum_stage.sv
// Purpose: randomized and directed checks of sum_stage against a sample-list model.
// Latency: n/a (testbench).
// Backpressure: drives random sum_out_sync stalls on the COUNT=4 instance.
module tb_sum_stage;
    localparam int COUNT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sum_stage_if b4();
    sum_stage_if b1();

    sum_stage #(.COUNT(COUNT)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    sum_stage #(.COUNT(1))     dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
    } res_t;

    int     n_chk  = 0;
    int     n_pass = 0;
    res_t   exp_q[$];     // results the model expects, oldest first
    longint part[$];      // samples of the sum currently being gathered
    res_t   last;
    int     n_out  = 0;
    logic [31:0] exp1_q[$];
    logic [31:0] out1[$];
    int     n_in1  = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: sum of the sample list with plain wide arithmetic.
    function automatic res_t model_sum(longint s[$]);
        res_t   r;
        longint a = 0;
        bit     o = 0;
        foreach (s[i]) begin
            a += s[i];
`ifdef SUM_STAGE_SAT_EN
            if (a > 64'sd2147483647) begin a = 64'sd2147483647; o = 1; end
            else if (a < -64'sd2147483648) begin a = -64'sd2147483648; o = 1; end
`endif
        end
        r.sum = a[31:0];
        r.ovf = o;
        return r;
    endfunction

    // Monitor / scoreboard for the COUNT=4 instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            part.delete();
        end else begin
            chk("in_notify", b4.sum_in_notify, exp_q.size() == 0);
            chk("out_notify", b4.sum_out_notify, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("sum_out", b4.sum_out, exp_q[0].sum);
                chk("ovf_out", b4.ovf_out, exp_q[0].ovf);
            end
            if (b4.sum_out_notify && b4.sum_out_sync) begin
                if (exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 1);
                else begin
                    last = exp_q.pop_front();
                    n_out++;
                end
            end
            if (b4.sum_in_notify && b4.sum_in_sync) begin
                part.push_back(longint'(b4.sum_in));
                if (part.size() == COUNT || b4.flush) begin
                    exp_q.push_back(model_sum(part));
                    part.delete();
                end
            end else if (b4.sum_in_notify && b4.flush && part.size() > 0) begin
                exp_q.push_back(model_sum(part));
                part.delete();
            end
        end
    end

    // Monitor for the COUNT=1 instance: every accepted sample is its own sum.
    always @(negedge clk) begin
        if (rst) begin
            exp1_q.delete();
        end else begin
            chk("c1_in_notify", b1.sum_in_notify, exp1_q.size() == 0);
            if (b1.sum_out_notify && b1.sum_out_sync) begin
                if (exp1_q.size() == 0) chk("c1_unexpected_out", exp1_q.size(), 1);
                else begin
                    chk("c1_sum_out", b1.sum_out, exp1_q[0]);
                    out1.push_back(b1.sum_out);
                    void'(exp1_q.pop_front());
                end
            end
            if (b1.sum_in_notify && b1.sum_in_sync) begin
                exp1_q.push_back(b1.sum_in);
                n_in1++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(logic sync, logic signed [31:0] d, logic fl, logic osync);
        b4.sum_in_sync  = sync;
        b4.sum_in       = d;
        b4.flush        = fl;
        b4.sum_out_sync = osync;
        cyc();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drv(1'b0, 32'sd0, 1'b0, 1'b1);
    endtask

    initial begin
        int          n0;
        logic [31:0] v;
        rst = 1'b1;
        b4.sum_in_sync = 0; b4.sum_in = 0; b4.flush = 0; b4.sum_out_sync = 0;
        b1.sum_in_sync = 0; b1.sum_in = 0; b1.flush = 0; b1.sum_out_sync = 1;
        #1;
        chk("rst_in_notify", b4.sum_in_notify, 1);
        chk("rst_out_notify", b4.sum_out_notify, 0);
        chk("rst_sum_out", b4.sum_out, 0);
        chk("rst_ovf_out", b4.ovf_out, 0);
        chk("c1_rst_out_notify", b1.sum_out_notify, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // 1,2,3,4 back to back
        drv(1, 1, 0, 1); drv(1, 2, 0, 1); drv(1, 3, 0, 1); drv(1, 4, 0, 1);
        idle(2);
        chk("t1_sum", last.sum, 10);
        chk("t1_count", n_out, 1);

        // 10..40 with a 5-cycle downstream stall; offered sample not consumed
        drv(1, 10, 0, 0); drv(1, 20, 0, 0); drv(1, 30, 0, 0); drv(1, 40, 0, 0);
        for (int i = 0; i < 5; i++) drv(1, 99, 0, 0);
        drv(1, 99, 0, 1);
        idle(2);
        chk("t2_sum", last.sum, 100);
        chk("t2_part", part.size(), 0);

        // flush alone, flush on empty, flush with a sample
        drv(1, 5, 0, 1); drv(1, -3, 0, 1); drv(0, 0, 1, 1);
        idle(2);
        chk("t3a_sum", last.sum, 2);
        n0 = n_out;
        drv(0, 0, 1, 1); drv(0, 0, 1, 1);
        idle(2);
        chk("t3b_no_out", n_out, n0);
        drv(1, 5, 0, 1); drv(1, -3, 0, 1); drv(1, 7, 1, 1);
        idle(2);
        chk("t3c_sum", last.sum, 9);

        // overflow over two samples, then a clean packet
        drv(1, 32'sh7FFF_FFF0, 0, 1); drv(1, 32'sh20, 1, 1);
        idle(2);
`ifdef SUM_STAGE_SAT_EN
        chk("t4_sum", last.sum, 32'h7FFF_FFFF);
        chk("t4_ovf", last.ovf, 1);
`else
        chk("t4_sum", last.sum, 32'h8000_0010);
        chk("t4_ovf", last.ovf, 0);
`endif
        drv(1, 1, 0, 1); drv(1, 1, 1, 1);
        idle(2);
        chk("t4b_sum", last.sum, 2);
        chk("t4b_ovf", last.ovf, 0);

        // reset in the middle of a sum
        drv(1, 1, 0, 1); drv(1, 1, 0, 1); drv(1, 1, 0, 1);
        rst = 1'b1;
        #1;
        chk("t5_in_notify", b4.sum_in_notify, 1);
        chk("t5_out_notify", b4.sum_out_notify, 0);
        chk("t5_sum_out", b4.sum_out, 0);
        cyc();
        rst = 1'b0;
        drv(1, 1, 0, 1); drv(1, 1, 0, 1); drv(1, 1, 0, 1); drv(1, 1, 0, 1);
        idle(2);
        chk("t5_sum", last.sum, 4);

        // COUNT=1 instance: -7 then 8, one sample per two cycles
        b1.sum_in_sync = 1; b1.sum_in = -7;
        cyc();
        b1.sum_in = 8;
        cyc(); cyc();
        b1.sum_in_sync = 0;
        cyc(); cyc();
        chk("c1_n_in", n_in1, 2);
        chk("c1_n_out", out1.size(), 2);
        if (out1.size() == 2) begin
            chk("c1_first", out1[0], -32'sd7);
            chk("c1_second", out1[1], 32'sd8);
        end

        // randomized traffic with stalls, flushes and near-limit values
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: v = 32'($urandom_range(0, 200)) - 32'd100;
                1: v = 32'h7000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
                2: v = 32'h9000_0000 - 32'($urandom_range(0, 32'h0FFF_FFFF));
                default: v = $urandom;
            endcase
            drv($urandom_range(0, 9) < 7, v, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 6);
        end
        drv(0, 0, 1, 1);
        idle(6);
        chk("drain_exp_q", exp_q.size(), 0);
        chk("drain_part", part.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
